ddr3_init_seq: RTL and testbench
================================

Name: ddr3_init_seq

Overview:
Parametrised DDR3 power-up/initialisation sequencer for 1..4 ranks. It drives the DDR3 command/address pins from a reset-pin phase through MR2/MR3/MR1/MR0 programming and ZQCL calibration. It then asserts ready and hands the bus to the controller.
- Over the single-rank engine it adds:
  - timing and MR values set by parameter
  - per-rank sequencing
  - DIMM address mirroring on odd ranks
  - re-initialisation on request
  - a busy flag

Parameters:
N_RANKS, 1, number of ranks (1..4); one csbar/cke/odt bit per rank
ADDR_W, 13, address bus width (13..16)
CNT_W, 20, wait-timer width; every T_* must be < 2**CNT_W
T_RSTL, 125000, cycles resetbar held low
T_CKE_WAIT, 312500, cycles from resetbar high to cke high
T_XPR, 76, NOP cycles after cke high before first MRS
T_CMD, 2, cycles each MRS/ZQCL command is held on the pins
T_MRD, 6, NOP cycles after MR2/MR3/MR1
T_MOD, 30, NOP cycles after MR0
T_ZQINIT, 1024, NOP cycles after ZQCL
MR0_VAL, 13'h0510, MR0 value: WR=6, DLL reset, CL=5, BL8
MR1_VAL, 13'h0010, MR1 value: AL=CL-2, DLL on, RTT off
MR2_VAL, 13'h0000, MR2 value: CWL=5
MR3_VAL, 13'h0000, MR3 value: MPR off
MIRROR, 1, 1 = apply address mirroring to odd ranks

Ports:
clk  in  1  clock
RESET  in  1  reset; RESET, synchronous, active-high; clock clk
init  in  1  start request; rising edge detected after one register stage
ready  out  1  initialisation complete
busy  out  1  sequence in progress
resetbar  out  1  DDR3 RESET#
cke  out  N_RANKS  clock enable per rank
csbar  out  N_RANKS  chip select per rank, active-low
rasbar, casbar, webar  out  1 each  command pins
ba  out  3  bank address
a  out  ADDR_W  address
odt  out  N_RANKS  held 0 throughout
ts_con  out  1  DQ tristate control; held 0 (bus not driven)

Behaviour:
- Reset (RESET=1 at a clk edge): on the next state, all outputs take reset values:
  - resetbar=0, cke=0, csbar=all 1, ras/cas/we=1, ba=0, a=0, odt=0, ts_con=0, ready=0, busy=0
  - state=IDLE, init edge detector cleared.
- RESET asserted mid-sequence aborts immediately, with the same values.
- Cycle S: the first edge after the registered init goes 0->1. busy=1 from S.
- State sequence, each wait state run by a down-counter loaded with the T_* value:
  - RST_LO: resetbar=0, cke=0, all csbar=1 for T_RSTL cycles.
  - CKE_WAIT: resetbar=1, cke=0 for T_CKE_WAIT cycles.
  - XPR: all cke=1, NOP on all ranks for T_XPR cycles.
  - Per rank r = 0..N_RANKS-1, in the order MR2, MR3, MR1, MR0:
    - MRS (csbar[r]=0, others 1, RAS/CAS/WE=000) held T_CMD cycles.
    - Then NOP (RAS/CAS/WE=111, csbar all 1) for T_MRD cycles; T_MOD after MR0.
    - Bank addresses: MR0=000, MR1=001, MR2=010, MR3=011.
  - ZQCL for rank r: RAS/CAS/WE=110, a[10]=1, other a bits 0, held T_CMD cycles, then NOP for T_ZQINIT cycles. Then the next rank.
  - DONE: after the last rank, NOP with csbar all 1; ready=1, busy=0 from the following cycle.
- Total cycles from S to ready=1: T_RSTL + T_CKE_WAIT + T_XPR + N_RANKS·(4·T_CMD + 3·T_MRD + T_MOD + T_CMD + T_ZQINIT).
- Mirroring: when MIRROR=1 and r is odd, swap A3/A4, A5/A6, A7/A8 and BA0/BA1 on MRS. ZQCL is unaffected.
- a bits above bit 12 are driven 0.
- init edge while busy: ignored.
- init edge in DONE: restarts from RST_LO; ready=0 and busy=1 at that cycle.
- A level-held init does not retrigger.
- N_RANKS, and any T_* value of 0 or >= 2**CNT_W, is out of range: reject with a simulation-time assertion.

Decomposition:
- Package ddr3_pkg holds:
  - command encodings (NOP=0111, MRS=0000, ZQCL=0110, including CS)
  - state enum
  - default MR constants
  - a mirror_addr function
- One sub-module, ddr3_wait_timer: CNT_W down-counter with load, value and done outputs.

Test Plan:
- Common overrides: N_RANKS=2, T_RSTL=4, T_CKE_WAIT=3, T_XPR=5, T_CMD=2, T_MRD=2, T_MOD=3, T_ZQINIT=6.
- Single init pulse:
  - resetbar rises at S+4; cke rises at S+7.
  - First MRS (rank0, ba=010) at S+12; ready=1 at S+62.
  - Exactly 10 non-NOP commands, each 2 cycles wide.
- Mirroring: rank1 MR0 shows a=13'h0488, ba=000; rank1 MR2 shows ba=001. Rank0 MR0 shows a=13'h0510.
- Chip selects: during rank0 commands csbar=2'b10; during rank1 commands csbar=2'b01; during every NOP csbar=2'b11.
- RESET at S+20: next cycle all outputs at reset values and busy=0. A new init gives the full 62-cycle sequence again.
- init pulsed at S+30: no effect.
- init pulsed after ready: ready=0 next cycle, sequence repeats, ready=1 62 cycles later.
- init held high for 200 cycles: only one sequence runs.

Source files
------------

// File: rtl/ddr3_init_seq_pkg.sv
// Shared definitions for the DDR3 initialisation sequencer.
// Holds the command encodings, FSM state codes, default mode-register values,
// the address/bank mirroring helpers and a parameter range helper.
package ddr3_pkg;

   // {cs#, ras#, cas#, we#}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_MRS  = 4'b0000;
   localparam logic [3:0] CMD_ZQCL = 4'b0110;

   typedef logic [3:0] state_t;
   localparam state_t ST_IDLE     = 4'd0;
   localparam state_t ST_RST_LO   = 4'd1;
   localparam state_t ST_CKE_WAIT = 4'd2;
   localparam state_t ST_XPR      = 4'd3;
   localparam state_t ST_MRS      = 4'd4;
   localparam state_t ST_MRS_WAIT = 4'd5;
   localparam state_t ST_ZQ       = 4'd6;
   localparam state_t ST_ZQ_WAIT  = 4'd7;
   localparam state_t ST_DONE     = 4'd8;

   localparam logic [12:0] MR0_DEFAULT = 13'h0510;
   localparam logic [12:0] MR1_DEFAULT = 13'h0010;
   localparam logic [12:0] MR2_DEFAULT = 13'h0000;
   localparam logic [12:0] MR3_DEFAULT = 13'h0000;

   // Odd ranks on a mirrored DIMM see A3/A4, A5/A6, A7/A8 swapped.
   function automatic logic [12:0] mirror_addr(input logic [12:0] a_in);
      logic [12:0] m;
      m    = a_in;
      m[3] = a_in[4];
      m[4] = a_in[3];
      m[5] = a_in[6];
      m[6] = a_in[5];
      m[7] = a_in[8];
      m[8] = a_in[7];
      return m;
   endfunction

   function automatic logic [2:0] mirror_ba(input logic [2:0] b);
      return {b[2], b[0], b[1]};
   endfunction

   function automatic bit t_ok(input longint t, input int w);
      return (t > 0) && (t < (longint'(1) << w));
   endfunction

endpackage

// File: rtl/ddr3_init_seq_if.sv
// DDR3 command/address pins plus the init/ready/busy handshake.
// master: the sequencer (drives pins, ready, busy; receives init)
// slave : memory side / controller (observes pins, drives init)
interface ddr3_init_seq_if #(
   parameter int N_RANKS = 1,
   parameter int ADDR_W  = 13
);
   logic                init;
   logic                ready;
   logic                busy;
   logic                resetbar;
   logic [N_RANKS-1:0]  cke;
   logic [N_RANKS-1:0]  csbar;
   logic                rasbar;
   logic                casbar;
   logic                webar;
   logic [2:0]          ba;
   logic [ADDR_W-1:0]   a;
   logic [N_RANKS-1:0]  odt;
   logic                ts_con;

   modport master (
      input  init,
      output ready, busy, resetbar, cke, csbar, rasbar, casbar, webar,
             ba, a, odt, ts_con
   );

   modport slave (
      output init,
      input  ready, busy, resetbar, cke, csbar, rasbar, casbar, webar,
             ba, a, odt, ts_con
   );
endinterface

// File: rtl/ddr3_wait_timer.sv
// Down-counter used for every wait phase of the init sequence.
// Ports: clk, RESET (sync, active-high), load/load_val (reload),
//        value (current count), done (count is zero).
module ddr3_wait_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             done
);

   always_ff @(posedge clk) begin
      if (RESET)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (value != '0)
         value <= value - CNT_W'(1);
   end

   assign done = (value == '0);

endmodule

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: reset pin phase, CKE, then per rank MR2/MR3/MR1/MR0
// and ZQCL, then ready. Odd ranks optionally get DIMM address mirroring.
// Ports: clk, RESET (sync, active-high), bus (master side of ddr3_init_seq_if).
//
// state       | meaning
// ST_IDLE     | after reset, pins parked, waiting for init edge
// ST_RST_LO   | resetbar low for T_RSTL
// ST_CKE_WAIT | resetbar high, cke low for T_CKE_WAIT
// ST_XPR      | cke high, NOP for T_XPR
// ST_MRS      | MRS for mode register mr_idx on rank, T_CMD cycles
// ST_MRS_WAIT | NOP for T_MRD (T_MOD after MR0)
// ST_ZQ       | ZQCL on rank, T_CMD cycles
// ST_ZQ_WAIT  | NOP for T_ZQINIT, then next rank or done
// ST_DONE     | ready, NOP; init edge restarts
module ddr3_init_seq
   import ddr3_pkg::*;
#(
   parameter int          N_RANKS    = 1,
   parameter int          ADDR_W     = 13,
   parameter int          CNT_W      = 20,
   parameter int          T_RSTL     = 125000,
   parameter int          T_CKE_WAIT = 312500,
   parameter int          T_XPR      = 76,
   parameter int          T_CMD      = 2,
   parameter int          T_MRD      = 6,
   parameter int          T_MOD      = 30,
   parameter int          T_ZQINIT   = 1024,
   parameter logic [12:0] MR0_VAL    = MR0_DEFAULT,
   parameter logic [12:0] MR1_VAL    = MR1_DEFAULT,
   parameter logic [12:0] MR2_VAL    = MR2_DEFAULT,
   parameter logic [12:0] MR3_VAL    = MR3_DEFAULT,
   parameter bit          MIRROR     = 1'b1
) (
   input logic              clk,
   input logic              RESET,
   ddr3_init_seq_if.master  bus
);

   localparam bit PARAMS_OK = (N_RANKS >= 1) && (N_RANKS <= 4) &&
                              (ADDR_W >= 13) && (ADDR_W <= 16) &&
                              t_ok(T_RSTL, CNT_W) && t_ok(T_CKE_WAIT, CNT_W) &&
                              t_ok(T_XPR, CNT_W) && t_ok(T_CMD, CNT_W) &&
                              t_ok(T_MRD, CNT_W) && t_ok(T_MOD, CNT_W) &&
                              t_ok(T_ZQINIT, CNT_W);

   // Timer counts down to zero, so each phase loads T-1.
   localparam logic [CNT_W-1:0] L_RSTL   = CNT_W'(T_RSTL - 1);
   localparam logic [CNT_W-1:0] L_CKE    = CNT_W'(T_CKE_WAIT - 1);
   localparam logic [CNT_W-1:0] L_XPR    = CNT_W'(T_XPR - 1);
   localparam logic [CNT_W-1:0] L_CMD    = CNT_W'(T_CMD - 1);
   localparam logic [CNT_W-1:0] L_MRD    = CNT_W'(T_MRD - 1);
   localparam logic [CNT_W-1:0] L_MOD    = CNT_W'(T_MOD - 1);
   localparam logic [CNT_W-1:0] L_ZQINIT = CNT_W'(T_ZQINIT - 1);
   localparam logic [1:0]       LAST_RANK = 2'(N_RANKS - 1);

   state_t             state;
   logic [1:0]         rank;
   logic [1:0]         mr_idx;      // 0..3 = MR2, MR3, MR1, MR0
   logic               init_q, init_q_d;
   logic               init_rise, start;
   logic               tmr_load, tmr_done;
   logic [CNT_W-1:0]   tmr_val, tmr_value;
   logic [3:0]         cmd;
   logic [12:0]        mr_val;
   logic [2:0]         mr_ba;
   logic [ADDR_W-1:0]  a_out;
   logic [2:0]         ba_out;
   logic [N_RANKS-1:0] cs_out;

   assign init_rise = init_q & ~init_q_d;
   assign start     = init_rise && (state == ST_IDLE || state == ST_DONE);

   ddr3_wait_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .RESET    (RESET),
      .load     (tmr_load),
      .load_val (tmr_val),
      .value    (tmr_value),
      .done     (tmr_done)
   );

   // The load for the next phase is issued on the last cycle of the current one.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE, ST_DONE: if (start)    begin tmr_load = 1'b1; tmr_val = L_RSTL; end
         ST_RST_LO:        if (tmr_done) begin tmr_load = 1'b1; tmr_val = L_CKE;  end
         ST_CKE_WAIT:      if (tmr_done) begin tmr_load = 1'b1; tmr_val = L_XPR;  end
         ST_XPR:           if (tmr_done) begin tmr_load = 1'b1; tmr_val = L_CMD;  end
         ST_MRS:           if (tmr_done) begin
                              tmr_load = 1'b1;
                              tmr_val  = (mr_idx == 2'd3) ? L_MOD : L_MRD;
                           end
         ST_MRS_WAIT:      if (tmr_done) begin tmr_load = 1'b1; tmr_val = L_CMD; end
         ST_ZQ:            if (tmr_done) begin tmr_load = 1'b1; tmr_val = L_ZQINIT; end
         ST_ZQ_WAIT:       if (tmr_done && rank != LAST_RANK) begin
                              tmr_load = 1'b1;
                              tmr_val  = L_CMD;
                           end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state    <= ST_IDLE;
         rank     <= 2'd0;
         mr_idx   <= 2'd0;
         init_q   <= 1'b0;
         init_q_d <= 1'b0;
      end else begin
         init_q   <= bus.init;
         init_q_d <= init_q;
         case (state)
            ST_IDLE, ST_DONE: if (start) begin
                                 state  <= ST_RST_LO;
                                 rank   <= 2'd0;
                                 mr_idx <= 2'd0;
                              end
            ST_RST_LO:   if (tmr_done) state <= ST_CKE_WAIT;
            ST_CKE_WAIT: if (tmr_done) state <= ST_XPR;
            ST_XPR:      if (tmr_done) state <= ST_MRS;
            ST_MRS:      if (tmr_done) state <= ST_MRS_WAIT;
            ST_MRS_WAIT: if (tmr_done) begin
                            if (mr_idx == 2'd3) begin
                               state <= ST_ZQ;
                            end else begin
                               mr_idx <= mr_idx + 2'd1;
                               state  <= ST_MRS;
                            end
                         end
            ST_ZQ:       if (tmr_done) state <= ST_ZQ_WAIT;
            ST_ZQ_WAIT:  if (tmr_done) begin
                            if (rank == LAST_RANK) begin
                               state <= ST_DONE;
                            end else begin
                               rank   <= rank + 2'd1;
                               mr_idx <= 2'd0;
                               state  <= ST_MRS;
                            end
                         end
            default:     state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      case (mr_idx)
         2'd0:    begin mr_val = MR2_VAL; mr_ba = 3'b010; end
         2'd1:    begin mr_val = MR3_VAL; mr_ba = 3'b011; end
         2'd2:    begin mr_val = MR1_VAL; mr_ba = 3'b001; end
         default: begin mr_val = MR0_VAL; mr_ba = 3'b000; end
      endcase
   end

   always_comb begin
      cmd    = CMD_NOP;
      a_out  = '0;
      ba_out = 3'b000;
      case (state)
         ST_MRS: begin
            cmd = CMD_MRS;
            if (MIRROR && rank[0]) begin
               a_out  = ADDR_W'(mirror_addr(mr_val));
               ba_out = mirror_ba(mr_ba);
            end else begin
               a_out  = ADDR_W'(mr_val);
               ba_out = mr_ba;
            end
         end
         ST_ZQ: begin
            cmd       = CMD_ZQCL;
            a_out[10] = 1'b1;
         end
         default: ;
      endcase
   end

   // NOP here is a deselect: chip select only drops during MRS/ZQCL.
   always_comb begin
      cs_out = '1;
      for (int i = 0; i < N_RANKS; i++) begin
         if ((state == ST_MRS || state == ST_ZQ) && rank == 2'(i) && !cmd[3])
            cs_out[i] = 1'b0;
      end
   end

   assign bus.resetbar = !(state == ST_IDLE || state == ST_RST_LO);
   assign bus.cke      = (state == ST_IDLE || state == ST_RST_LO || state == ST_CKE_WAIT)
                         ? '0 : '1;
   assign bus.csbar    = cs_out;
   assign bus.rasbar   = cmd[2];
   assign bus.casbar   = cmd[1];
   assign bus.webar    = cmd[0];
   assign bus.ba       = ba_out;
   assign bus.a        = a_out;
   assign bus.odt      = '0;
   assign bus.ts_con   = 1'b0;
   assign bus.ready    = (state == ST_DONE);
   assign bus.busy     = !(state == ST_IDLE || state == ST_DONE);

   always @(posedge clk) begin
      assert (PARAMS_OK)
         else $error("ddr3_init_seq: N_RANKS/ADDR_W/T_* parameter out of range");
      assert (tmr_done == (tmr_value == '0))
         else $error("ddr3_init_seq: wait timer done flag inconsistent");
   end

endmodule

// File: tb/tb_ddr3_init_seq.sv
module tb_ddr3_init_seq;

   logic clk = 1'b0;
   logic RESET;
   logic init;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ddr3_init_seq_if #(.N_RANKS(2), .ADDR_W(13)) bus ();

   assign bus.init = init;

   ddr3_init_seq #(
      .N_RANKS(2), .ADDR_W(13), .CNT_W(20),
      .T_RSTL(4), .T_CKE_WAIT(3), .T_XPR(5), .T_CMD(2),
      .T_MRD(2), .T_MOD(3), .T_ZQINIT(6), .MIRROR(1'b1)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   // {resetbar, cke[1:0], csbar[1:0], ras, cas, we, ba[2:0], a[12:0], odt[1:0], ts_con, ready, busy}
   logic [28:0] obs_vec;
   assign obs_vec = {bus.resetbar, bus.cke, bus.csbar, bus.rasbar, bus.casbar, bus.webar,
                     bus.ba, bus.a, bus.odt, bus.ts_con, bus.ready, bus.busy};

   localparam logic [28:0] RESET_VEC = {1'b0, 2'b00, 2'b11, 3'b111, 3'b000, 13'h0000,
                                        2'b00, 1'b0, 1'b0, 1'b0};

   // Command start cycles relative to S, each held two cycles.
   int          cmd_t   [10] = '{12, 16, 20, 24, 29, 37, 41, 45, 49, 54};
   logic [1:0]  cmd_cs  [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
   logic [2:0]  cmd_rcw [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110,
                                 3'b000, 3'b000, 3'b000, 3'b000, 3'b110};
   logic [2:0]  cmd_ba  [10] = '{3'd2, 3'd3, 3'd1, 3'd0, 3'd0,
                                 3'd1, 3'd3, 3'd2, 3'd0, 3'd0};
   logic [12:0] cmd_a   [10] = '{13'h000, 13'h000, 13'h010, 13'h510, 13'h400,
                                 13'h000, 13'h000, 13'h008, 13'h488, 13'h400};

   function automatic logic [28:0] exp_vec(input int k);
      logic        rb, rdy, bsy;
      logic [1:0]  cke, cs;
      logic [2:0]  rcw, ba;
      logic [12:0] a;
      rb  = (k >= 4);
      cke = (k >= 7) ? 2'b11 : 2'b00;
      cs  = 2'b11;
      rcw = 3'b111;
      ba  = 3'b000;
      a   = 13'h0000;
      rdy = (k >= 62);
      bsy = (k < 62);
      for (int i = 0; i < 10; i++) begin
         if (k == cmd_t[i] || k == cmd_t[i] + 1) begin
            cs  = cmd_cs[i];
            rcw = cmd_rcw[i];
            ba  = cmd_ba[i];
            a   = cmd_a[i];
         end
      end
      return {rb, cke, cs, rcw, ba, a, 2'b00, 1'b0, rdy, bsy};
   endfunction

   task automatic chk(input string tag, input int k, input logic [28:0] obs,
                      input logic [28:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called just after a negedge. Raises init so the registered copy rises at
   // the next posedge; the one after that is S. Sample k is taken at the
   // negedge following S+k.
   task automatic run_seq(input string tag, input int n_cyc, input int pulse_at,
                          input int reset_at, input bit hold);
      int ncmd, ncyc;
      bit prev_cmd, cur_cmd;
      ncmd = 0;
      ncyc = 0;
      prev_cmd = 1'b0;
      init = 1'b1;
      @(negedge clk);
      if (!hold) init = 1'b0;
      for (int k = 0; k < n_cyc; k++) begin
         @(negedge clk);
         if (reset_at >= 0 && k == reset_at) begin
            chk({tag, " reset"}, k, obs_vec, RESET_VEC);
            RESET = 1'b0;
            return;
         end
         chk(tag, k, obs_vec, exp_vec(k));
         cur_cmd = ({bus.rasbar, bus.casbar, bus.webar} != 3'b111);
         if (cur_cmd) ncyc++;
         if (cur_cmd && !prev_cmd) ncmd++;
         prev_cmd = cur_cmd;
         if (k == pulse_at)     init = 1'b1;
         if (k == pulse_at + 1) init = 1'b0;
         if (reset_at >= 0 && k == reset_at - 1) RESET = 1'b1;
      end
      if (hold) init = 1'b0;
      chk_int({tag, " cmd count"}, ncmd, 10);
      chk_int({tag, " cmd cycles"}, ncyc, 20);
   endtask

   initial begin
      RESET = 1'b1;
      init  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset state", 0, obs_vec, RESET_VEC);
      RESET = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("idle after reset", 0, obs_vec, RESET_VEC);
      end

      // First sequence from idle; a pulse at S+30 must be ignored.
      run_seq("seq1", 64, 30, -1, 1'b0);

      repeat (5) begin
         @(negedge clk);
         chk("ready hold", 62, obs_vec, exp_vec(62));
      end

      // Restart from DONE.
      run_seq("seq2 restart", 64, -1, -1, 1'b0);

      // Abort at S+20, then a clean full sequence.
      run_seq("seq3 abort", 40, -1, 20, 1'b0);
      @(negedge clk);
      chk("idle after abort", 0, obs_vec, RESET_VEC);
      run_seq("seq4 after abort", 64, -1, -1, 1'b0);

      // Level-held init: exactly one sequence.
      run_seq("seq5 held init", 200, -1, -1, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("ready after held", 62, obs_vec, exp_vec(62));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
